morph_filter_1bit: RTL and testbench
====================================

# morph_filter_1bit

Binary morphology stage consuming the 3x3 1-bit window produced by the upstream 3x3 binary matrix generator. It applies erosion, dilation, bypass or a 3x3 majority (median) filter to each window and emits one filtered pixel per valid window. Position counters track the column and row, and mode changes take effect only at frame boundaries. The output feeds the downstream pixel writer / display path.

## Interface
Parameters:
- IMG_W, 800, active pixels per line (window beats per row)
- IMG_H, 480, active lines per frame

Ports:
- sys_clk  input  1  single system clock; all logic rising-edge
- sys_rst_n  input  1  reset, asynchronous and active-low
- matrix_wr_en  input  1  window valid, one beat per pixel
- matrix_p11..matrix_p33  input  1 each  3x3 window; p22 is the centre pixel
- mode  input  2  00 erode, 01 dilate, 10 bypass, 11 majority
- morph_wr_en  output  1  output pixel valid
- morph_1bit  output  1  filtered pixel
- frame_done  output  1  one-cycle pulse with the last pixel of a frame

## Operation
- Counters: col 0..IMG_W-1 and row 0..IMG_H-1.
  - Both advance only on matrix_wr_en.
  - col wraps to 0 and increments row at col==IMG_W-1.
  - row wraps to 0 after row==IMG_H-1 with col==IMG_W-1, starting a new frame.
  - Width is $clog2 of the parameter.
- Mode latch: active_mode <= mode on a beat with col==0 and row==0. Mid-frame mode changes are ignored until the next frame's first beat; that beat already uses the new mode. Reset value of active_mode is 00.
- Filter functions:
  - erode = AND of all 9 taps.
  - dilate = OR of all 9 taps.
  - bypass = p22.
  - majority = 1 when the popcount of the 9 taps is >= 5. Popcount is a 4-bit adder tree.
- Border pixels are row 0, row IMG_H-1, col 0 and col IMG_W-1. Their handling is set by the Configuration section.
- Idle cycles (matrix_wr_en=0) hold counters, active_mode and morph_1bit. morph_wr_en is 0 and frame_done is 0.

## Timing
- Latency: 1 cycle, registered. morph_wr_en(t+1) = matrix_wr_en(t). morph_1bit(t+1) is computed from the window at t.
- Back-to-back beats are accepted every cycle. There is no backpressure and no stall input.
- frame_done(t+1)=1 exactly when the beat at t has row==IMG_H-1 and col==IMG_W-1. It coincides with that pixel's morph_wr_en.
- Reset values:
  - morph_wr_en=0, morph_1bit=0, frame_done=0.
  - col=0, row=0, active_mode=00.
- Reset mid-frame: counters return to 0 immediately. The next valid beat is treated as pixel (0,0) and re-latches mode.
- The first morph_wr_en after reset cannot occur earlier than the cycle after the first matrix_wr_en.

## Configuration
- MORPH_BORDER_CLEAR_EN defined:
  - Any beat whose position is a border pixel outputs morph_1bit=0, regardless of mode, including bypass.
  - morph_wr_en and frame_done are unaffected.
- MORPH_BORDER_CLEAR_EN undefined:
  - The border is not special. The filter result is output unmodified.
  - The border compare logic is not synthesised.

## Test plan
- Erode, all-ones window stream for a full frame -> morph_1bit=1 at interior pixels, with a 1-cycle lag. With the macro defined, 0 on the 2*800+2*478=2556 border pixels. frame_done high once, on the 384000th output beat.
- Dilate, single window with only p13=1 at interior (row 5, col 10) -> that output=1; all-zero windows -> 0. Erode of the same window -> 0.
- Majority: windows with popcount 4 -> 0, popcount 5 -> 1, popcount 9 -> 1. Bypass with p22=1 and others 0 -> 1.
- Mode change mid-frame (00 -> 01 at row 100) -> erosion persists to the end of the frame. Dilation applies from pixel (0,0) of the next frame.
- Gapped input (matrix_wr_en toggling 1/0) -> counters advance only on valid beats. frame_done still fires after exactly 384000 valid beats. Outputs hold during gaps.
- Assert sys_rst_n low at row 200, col 37 -> all outputs are 0 immediately. After release, the next beat is (0,0): no frame_done until 384000 further beats, and the mode is re-latched.

Source files
------------

// File: rtl/morph_filter_1bit.sv
// 3x3 binary morphology stage: erode / dilate / bypass / majority on each valid window, 1-cycle latency.
// Optional MORPH_BORDER_CLEAR_EN forces border-position outputs to 0.
module morph_filter_1bit #(
  parameter int IMG_W = 800,
  parameter int IMG_H = 480
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       matrix_wr_en,
  input  logic       matrix_p11,
  input  logic       matrix_p12,
  input  logic       matrix_p13,
  input  logic       matrix_p21,
  input  logic       matrix_p22,
  input  logic       matrix_p23,
  input  logic       matrix_p31,
  input  logic       matrix_p32,
  input  logic       matrix_p33,
  input  logic [1:0] mode,
  output logic       morph_wr_en,
  output logic       morph_1bit,
  output logic       frame_done
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  localparam logic [1:0] M_ERODE  = 2'b00;
  localparam logic [1:0] M_DILATE = 2'b01;
  localparam logic [1:0] M_BYPASS = 2'b10;

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [1:0]    r_mode;
  logic          r_wr_en, r_pix, r_done;

  logic [8:0] w_taps;
  logic       w_first, w_col_last, w_row_last, w_filt, w_pix;
  logic [1:0] w_mode;
  logic [1:0] w_s0, w_s1, w_s2, w_s3;
  logic [2:0] w_s01, w_s23;
  logic [3:0] w_pop;

  assign w_taps = {matrix_p11, matrix_p12, matrix_p13,
                   matrix_p21, matrix_p22, matrix_p23,
                   matrix_p31, matrix_p32, matrix_p33};

  // Popcount as a small adder tree: pairs -> quads -> eight, plus the ninth tap.
  assign w_s0  = {1'b0, w_taps[0]} + {1'b0, w_taps[1]};
  assign w_s1  = {1'b0, w_taps[2]} + {1'b0, w_taps[3]};
  assign w_s2  = {1'b0, w_taps[4]} + {1'b0, w_taps[5]};
  assign w_s3  = {1'b0, w_taps[6]} + {1'b0, w_taps[7]};
  assign w_s01 = {1'b0, w_s0} + {1'b0, w_s1};
  assign w_s23 = {1'b0, w_s2} + {1'b0, w_s3};
  assign w_pop = {1'b0, w_s01} + {1'b0, w_s23} + {3'b000, w_taps[8]};

  assign w_col_last = (r_col == COL_LAST);
  assign w_row_last = (r_row == ROW_LAST);
  assign w_first    = (r_col == '0) && (r_row == '0);
  // The first beat of a frame already runs in the newly sampled mode.
  assign w_mode     = w_first ? mode : r_mode;

  always_comb begin
    w_filt = 1'b0;
    case (w_mode)
      M_ERODE:  w_filt = &w_taps;
      M_DILATE: w_filt = |w_taps;
      M_BYPASS: w_filt = matrix_p22;
      default:  w_filt = (w_pop >= 4'd5);
    endcase
  end

`ifdef MORPH_BORDER_CLEAR_EN
  logic w_border;
  assign w_border = (r_row == '0) || w_row_last || (r_col == '0) || w_col_last;
  assign w_pix    = w_filt & ~w_border;
`else
  assign w_pix    = w_filt;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_col   <= '0;
      r_row   <= '0;
      r_mode  <= M_ERODE;
      r_wr_en <= 1'b0;
      r_pix   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_wr_en <= matrix_wr_en;
      r_done  <= matrix_wr_en && w_col_last && w_row_last;
      if (matrix_wr_en) begin
        r_pix  <= w_pix;
        r_mode <= w_mode;
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  assign morph_wr_en = r_wr_en;
  assign morph_1bit  = r_pix;
  assign frame_done  = r_done;
endmodule

// File: tb/tb_morph_filter_1bit.sv
// Scoreboard bench: random windows, gaps, mode changes and a mid-frame reset against a position/mode reference model.
module tb_morph_filter_1bit;
  localparam int W = 12;
  localparam int H = 6;
  localparam int NBEATS = 700;
  localparam int RST_AT = 300;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       en = 1'b0;
  logic [8:0] win = '0;
  logic [1:0] mode = 2'b00;
  logic       morph_wr_en, morph_1bit, frame_done;

  morph_filter_1bit #(.IMG_W(W), .IMG_H(H)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .matrix_wr_en(en),
    .matrix_p11(win[8]), .matrix_p12(win[7]), .matrix_p13(win[6]),
    .matrix_p21(win[5]), .matrix_p22(win[4]), .matrix_p23(win[3]),
    .matrix_p31(win[2]), .matrix_p32(win[1]), .matrix_p33(win[0]),
    .mode(mode), .morph_wr_en(morph_wr_en), .morph_1bit(morph_1bit), .frame_done(frame_done)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct { bit pix; bit fd; } exp_t;
  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int frames = 0;

  // Reference model state: plain integer raster position and the frame's mode.
  int col = 0, row = 0;
  logic [1:0] amode = 2'b00;

  function automatic bit ref_pix(input logic [1:0] m, input logic [8:0] w, input int c, input int r);
    bit p;
    case (m)
      2'b00:   p = (w == 9'h1ff);
      2'b01:   p = (w != 9'h000);
      2'b10:   p = w[4];
      default: p = ($countones(w) >= 5);
    endcase
`ifdef MORPH_BORDER_CLEAR_EN
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) p = 1'b0;
`endif
    return p;
  endfunction

  function automatic logic [8:0] gen_win();
    int k;
    logic [8:0] w;
    k = $urandom_range(0, 7);
    case (k)
      0: w = 9'h1ff;
      1: w = 9'h000;
      2: w = 9'h010;
      3: w = 9'h040;
      default: w = 9'($urandom);
    endcase
    return w;
  endfunction

  // Monitor: pops an expectation on every output beat, checks hold/idle otherwise.
  bit last_pix = 1'b0;
  always @(negedge sys_clk) begin
    exp_t e;
    if (!sys_rst_n) begin
      checks++;
      if (morph_wr_en || morph_1bit || frame_done) begin
        errors++;
        $display("FAIL reset_outputs: got wr=%0b pix=%0b fd=%0b, want 0 0 0", morph_wr_en, morph_1bit, frame_done);
      end
      last_pix = 1'b0;
    end else if (morph_wr_en) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got an output beat, want none (queue empty)");
      end else begin
        e = q.pop_front();
        if (morph_1bit !== e.pix) begin
          errors++;
          $display("FAIL pixel: got %0b, want %0b", morph_1bit, e.pix);
        end
        checks++;
        if (frame_done !== e.fd) begin
          errors++;
          $display("FAIL frame_done: got %0b, want %0b", frame_done, e.fd);
        end
      end
      last_pix = morph_1bit;
    end else begin
      checks++;
      if (frame_done !== 1'b0 || morph_1bit !== last_pix) begin
        errors++;
        $display("FAIL idle_hold: got pix=%0b fd=%0b, want pix=%0b fd=0", morph_1bit, frame_done, last_pix);
      end
    end
  end

  initial begin
    exp_t e;
    bit v;
    repeat (3) @(negedge sys_clk);
    #2 sys_rst_n = 1'b1;
    for (int n = 0; n < NBEATS; n++) begin
      @(negedge sys_clk);
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom);
      v = ($urandom_range(0, 9) > 2);
      en = v;
      win = gen_win();
      if (v) begin
        if (col == 0 && row == 0) amode = mode;
        e.pix = ref_pix(amode, win, col, row);
        e.fd = (col == W - 1 && row == H - 1);
        if (e.fd) frames++;
        q.push_back(e);
        if (col == W - 1) begin
          col = 0;
          row = (row == H - 1) ? 0 : row + 1;
        end else begin
          col++;
        end
      end
      if (n == RST_AT) begin
        @(negedge sys_clk);
        en = 1'b0;
        #2 sys_rst_n = 1'b0;
        #1;
        checks++;
        if (morph_wr_en || morph_1bit || frame_done) begin
          errors++;
          $display("FAIL async_reset: got wr=%0b pix=%0b fd=%0b, want 0 0 0", morph_wr_en, morph_1bit, frame_done);
        end
        col = 0;
        row = 0;
        amode = 2'b00;
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b1;
      end
    end
    @(negedge sys_clk);
    en = 1'b0;
    repeat (3) @(negedge sys_clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    checks++;
    if (frames < 2) begin
      errors++;
      $display("FAIL frame_count: got %0d completed frames in stimulus, want >= 2", frames);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
